// File: rtl/ysyx_201979054_burst_read_ctrl.sv
// AXI4-Lite burst reader: issues BURST_LEN single-beat reads, one outstanding at a time,
// stepping the address by INCR_VAL and streaming each returned beat with its index.
module ysyx_201979054_burst_read_ctrl #(
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned BURST_LEN      = 16,
    parameter int unsigned INCR_VAL       = 4
) (
    input  logic                      clk,
    input  logic                      arstn,
    input  logic                      start,
    input  logic [AXI_ADDR_WIDTH-1:0] i_base_addr,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_error,
    output logic [AXI_DATA_WIDTH-1:0] o_data,
    output logic                      o_data_valid,
    output logic [7:0]                o_beat_idx,
    output logic [AXI_ADDR_WIDTH-1:0] o_araddr,
    output logic                      o_arvalid,
    input  logic                      i_arready,
    input  logic [AXI_DATA_WIDTH-1:0] i_rdata,
    input  logic [1:0]                i_rresp,
    input  logic                      i_rvalid,
    output logic                      o_rready
);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        DONE
    } state_t;

    localparam logic [7:0]                LAST_IDX  = 8'(BURST_LEN - 1);
    localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_STEP = AXI_ADDR_WIDTH'(INCR_VAL);

    state_t                    state_q;
    state_t                    state_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q;
    logic [7:0]                cnt_q;
    logic                      beat_fire;
    logic                      resp_err;

    assign beat_fire = (state_q == DATA) && i_rvalid;
    assign resp_err  = (i_rresp != 2'b00);
    assign o_araddr  = addr_q;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        o_arvalid = 1'b0;
        o_rready  = 1'b0;
        o_busy    = 1'b1;
        o_done    = 1'b0;
        case (state_q)
            IDLE: begin
                o_busy = 1'b0;
                if (start) begin
                    state_d = ADDR;
                end
            end
            ADDR: begin
                o_arvalid = 1'b1;
                if (i_arready) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                o_rready = 1'b1;
                if (i_rvalid) begin
                    // An error response aborts the remaining beats.
                    if (resp_err || (cnt_q == LAST_IDX)) begin
                        state_d = DONE;
                    end else begin
                        state_d = ADDR;
                    end
                end
            end
            DONE: begin
                o_done  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            addr_q       <= '0;
            cnt_q        <= '0;
            o_data       <= '0;
            o_beat_idx   <= '0;
            o_data_valid <= 1'b0;
            o_error      <= 1'b0;
        end else begin
            o_data_valid <= 1'b0;
            if ((state_q == IDLE) && start) begin
                addr_q  <= i_base_addr;
                cnt_q   <= '0;
                o_error <= 1'b0;
            end
            if (beat_fire) begin
                o_data       <= i_rdata;
                o_beat_idx   <= cnt_q;
                o_data_valid <= 1'b1;
                if (resp_err) begin
                    o_error <= 1'b1;
                end else if (cnt_q != LAST_IDX) begin
                    addr_q <= addr_q + ADDR_STEP;
                    cnt_q  <= cnt_q + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ysyx_201979054_burst_read_ctrl.sv
// Bench for the burst reader: directed scenario table, reset corner cases and
// randomized bursts against an arithmetic model of addresses, beat counts and latency.
module tb_ysyx_201979054_burst_read_ctrl;

    localparam int unsigned AW  = 64;
    localparam int unsigned DW  = 32;
    localparam int unsigned BL  = 16;
    localparam int unsigned INC = 4;
    localparam int          BUDGET = 300;
    localparam int          NVEC   = 7;

    logic          clk = 1'b0;
    logic          arstn;
    logic          start;
    logic [AW-1:0] base_addr;
    logic          o_busy;
    logic          o_done;
    logic          o_error;
    logic [DW-1:0] o_data;
    logic          o_data_valid;
    logic [7:0]    o_beat_idx;
    logic [AW-1:0] o_araddr;
    logic          o_arvalid;
    logic          i_arready;
    logic [DW-1:0] i_rdata;
    logic [1:0]    i_rresp;
    logic          i_rvalid;
    logic          o_rready;

    always #5 clk = ~clk;

    ysyx_201979054_burst_read_ctrl #(
        .AXI_ADDR_WIDTH(AW),
        .AXI_DATA_WIDTH(DW),
        .BURST_LEN     (BL),
        .INCR_VAL      (INC)
    ) u_dut (
        .clk         (clk),
        .arstn       (arstn),
        .start       (start),
        .i_base_addr (base_addr),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_error     (o_error),
        .o_data      (o_data),
        .o_data_valid(o_data_valid),
        .o_beat_idx  (o_beat_idx),
        .o_araddr    (o_araddr),
        .o_arvalid   (o_arvalid),
        .i_arready   (i_arready),
        .i_rdata     (i_rdata),
        .i_rresp     (i_rresp),
        .i_rvalid    (i_rvalid),
        .o_rready    (o_rready)
    );

    typedef struct {
        logic [63:0] base;
        int          err_beat;     // -1: no error response
        int          wait_beat;    // AR phase that gets wait_len stall cycles, -1: none
        int          wait_len;
        int          restart_cyc;  // cycle after start at which a stray start is pulsed, 0: none
        int          exp_beats;
        logic        exp_err;
        int          exp_latency;
        logic [63:0] exp_last_addr;
    } vec_t;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic int model_beats(input int err_beat);
        return (err_beat >= 0 && err_beat < int'(BL)) ? err_beat + 1 : int'(BL);
    endfunction

    function automatic logic [63:0] model_addr(input logic [63:0] base, input int k);
        return base + 64'(INC) * 64'(k);
    endfunction

    task automatic idle_inputs();
        start     = 1'b0;
        i_arready = 1'b0;
        i_rvalid  = 1'b0;
        i_rresp   = 2'b00;
        i_rdata   = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},    o_busy,       0);
        check({tag, "_done"},    o_done,       0);
        check({tag, "_error"},   o_error,      0);
        check({tag, "_data"},    o_data,       0);
        check({tag, "_dvalid"},  o_data_valid, 0);
        check({tag, "_idx"},     o_beat_idx,   0);
        check({tag, "_araddr"},  o_araddr,     0);
        check({tag, "_arvalid"}, o_arvalid,    0);
        check({tag, "_rready"},  o_rready,     0);
    endtask

    // Acts as the AXI slave for one burst and checks per-beat behaviour against the model.
    task automatic run_burst(input logic [63:0] base, input int err_beat, input int wait_beat,
                             input int wait_len, input bit rnd, input int restart_cyc,
                             output int beats, output logic err_o, output int latency,
                             output logic [63:0] last_addr, output int total_wait);
        logic [31:0] sent[$];
        int ar_cnt = 0, r_cnt = 0, dv_cnt = 0, done_cnt = 0, cyc = 0;
        int ar_left = -1, r_left = -1, n_exp;
        bit addr_bad = 0, busy_bad = 0, idx_bad = 0, data_bad = 0, done_seen = 0;
        n_exp      = model_beats(err_beat);
        latency    = 0;
        last_addr  = '0;
        total_wait = 0;
        start      = 1'b1;
        base_addr  = base;
        while (!done_seen && cyc < BUDGET) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) check("err_cleared_on_start", o_error, 0);
            if (!o_busy) busy_bad = 1;
            if (o_data_valid) begin
                if (dv_cnt >= sent.size()) idx_bad = 1;
                else begin
                    if (o_beat_idx != 8'(dv_cnt)) idx_bad = 1;
                    if (o_data != sent[dv_cnt]) data_bad = 1;
                end
                dv_cnt++;
            end
            if (o_done) begin
                done_cnt++;
                latency   = cyc;
                done_seen = 1;
            end
            start = (cyc == restart_cyc);
            if (cyc == restart_cyc) base_addr = 64'h9000;
            i_arready = 1'b0;
            i_rvalid  = 1'b0;
            i_rresp   = 2'b00;
            i_rdata   = $urandom;
            if (o_arvalid) begin
                if (o_araddr != model_addr(base, ar_cnt)) addr_bad = 1;
                if (ar_left < 0) begin
                    ar_left = (ar_cnt == wait_beat) ? wait_len
                            : (rnd ? int'($urandom_range(0, 2)) : 0);
                    total_wait += ar_left;
                end
                if (ar_left == 0) begin
                    i_arready = 1'b1;
                    last_addr = o_araddr;
                    ar_cnt++;
                    ar_left = -1;
                end else ar_left--;
            end else if (ar_left >= 0) addr_bad = 1;
            if (o_rready) begin
                if (r_left < 0) begin
                    r_left = rnd ? int'($urandom_range(0, 2)) : 0;
                    total_wait += r_left;
                end
                if (r_left == 0) begin
                    i_rvalid = 1'b1;
                    i_rdata  = $urandom;
                    sent.push_back(i_rdata);
                    if (r_cnt == err_beat)
                        i_rresp = rnd ? 2'($urandom_range(1, 3)) : 2'b10;
                    r_cnt++;
                    r_left = -1;
                end else r_left--;
            end
        end
        check("done_within_budget", done_seen, 1);
        @(posedge clk); #1;
        idle_inputs();
        check("busy_low_after_done", o_busy, 0);
        check("done_single_pulse", o_done, 0);
        check("ar_count", ar_cnt, n_exp);
        check("r_count", r_cnt, n_exp);
        check("dvalid_count", dv_cnt, n_exp);
        check("done_count", done_cnt, 1);
        check("araddr_sequence_ok", addr_bad, 0);
        check("beat_idx_ok", idx_bad, 0);
        check("beat_data_ok", data_bad, 0);
        check("busy_through_burst", busy_bad, 0);
        repeat (3) @(posedge clk);
        #1;
        err_o = o_error;
        beats = dv_cnt;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t        tbl[NVEC];
        int          beats, lat, tw, cyc, n, eb;
        logic        err;
        logic [63:0] last, b;
        bit          bad;

        tbl[0] = '{64'h1000, -1, -1, 0,  0, 16, 1'b0, 33, 64'h103C};
        tbl[1] = '{64'h1000, -1,  3, 5,  0, 16, 1'b0, 38, 64'h103C};
        tbl[2] = '{64'h2000,  2, -1, 0,  0,  3, 1'b1,  7, 64'h2008};
        tbl[3] = '{64'hFFFF_FFFF_FFFF_FFF8, -1, -1, 0, 0, 16, 1'b0, 33, 64'h34};
        tbl[4] = '{64'h3000, -1, -1, 0,  4, 16, 1'b0, 33, 64'h303C};
        tbl[5] = '{64'h4000, 15, -1, 0, 33, 16, 1'b1, 33, 64'h403C};
        tbl[6] = '{64'h0010,  0, -1, 0,  0,  1, 1'b1,  3, 64'h0010};

        arstn     = 1'b0;
        base_addr = '0;
        idle_inputs();
        #12;
        check_all_zero("reset");
        @(negedge clk) arstn = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < NVEC; i++) begin
            run_burst(tbl[i].base, tbl[i].err_beat, tbl[i].wait_beat, tbl[i].wait_len, 1'b0,
                      tbl[i].restart_cyc, beats, err, lat, last, tw);
            check($sformatf("vec%0d_beats", i), beats, tbl[i].exp_beats);
            check($sformatf("vec%0d_error", i), err, tbl[i].exp_err);
            check($sformatf("vec%0d_latency", i), lat, tbl[i].exp_latency);
            check($sformatf("vec%0d_last_araddr", i), last, tbl[i].exp_last_addr);
        end

        // Reset asserted in DATA while a read response is being presented.
        start     = 1'b1;
        base_addr = 64'h5000;
        cyc       = 0;
        while (!o_rready && cyc < 50) begin
            @(posedge clk); #1;
            start     = 1'b0;
            i_arready = o_arvalid;
            cyc++;
        end
        check("mid_reset_reached_data", o_rready, 1);
        i_arready = 1'b0;
        i_rvalid  = 1'b1;
        i_rdata   = 32'hCAFE_F00D;
        #2 arstn = 1'b0;
        #1;
        check_all_zero("mid_reset");
        bad = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (o_done || o_busy || o_data_valid) bad = 1;
        end
        check("no_activity_in_reset", bad, 0);
        @(negedge clk);
        arstn = 1'b1;
        idle_inputs();
        bad = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (o_done || o_busy || o_data_valid || o_arvalid) bad = 1;
        end
        check("idle_after_reset_release", bad, 0);

        for (int i = 0; i < 20; i++) begin
            b  = {$urandom, $urandom};
            eb = int'($urandom_range(0, 40));
            if (eb >= int'(BL)) eb = -1;
            run_burst(b, eb, -1, 0, 1'b1, int'($urandom_range(0, 12)), beats, err, lat, last, tw);
            n = model_beats(eb);
            check($sformatf("rnd%0d_beats", i), beats, n);
            check($sformatf("rnd%0d_error", i), err, eb >= 0);
            check($sformatf("rnd%0d_latency", i), lat, 2 * n + 1 + tw);
            check($sformatf("rnd%0d_last_araddr", i), last, model_addr(b, n - 1));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
